// File: rtl/bc_pkg.sv
// Shared Bulls-and-Cows definitions: digit geometry, LFSR polynomial and draw FSM states.
package bc_pkg;

   localparam int          BC_DIGITS = 4;
   localparam logic [3:0]  BCD_MAX   = 4'd9;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      IDLE,
      DRAW,
      FILL
   } state_t;

   // Right-shifting Galois step with the keypad bit folded into the new LSB.
   function automatic logic [15:0] lfsr_next(input logic [15:0] q, input logic ent);
      return ({1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000)) ^ {15'b0, ent};
   endfunction

   function automatic logic [3:0] lfsr_digit(input logic [15:0] q);
      return q[3:0];
   endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR with entropy injection; steps every cycle, no stall.
// An all-zero next state would lock up, so the seed is reloaded in its place.
module lfsr16
   import bc_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        entropy_in,
   output logic [15:0] q
);

   logic [15:0] r_q;
   logic [15:0] w_next;

   always_comb w_next = lfsr_next(r_q, entropy_in);

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_q <= SEED;
      else if (w_next == 16'h0000)
         r_q <= SEED;
      else
         r_q <= w_next;
   end

   assign q = r_q;

endmodule

// File: rtl/secret_gen.sv
// Draws a 4-digit distinct BCD secret per new_game request; 5..MAX_TRIES+5 cycles to valid.
// Requests while busy are dropped; the answer only changes at reset or a full commit.
module secret_gen
   import bc_pkg::*;
#(
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter logic [15:0] RESET_ANSWER = 16'h1234,
   parameter bit          ALLOW_LZ     = 1'b1,
   parameter int          MAX_TRIES    = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        new_game,
   input  logic        entropy_in,
   output logic [15:0] answer,
   output logic        answer_valid,
   output logic        busy
);

   localparam int            TW         = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);
   localparam logic [TW-1:0] TRIES_LAST = TW'(MAX_TRIES - 1);

   state_t        r_state;
   logic [9:0]    r_used;
   logic [15:0]   r_shadow;
   logic [1:0]    r_slot;
   logic [TW-1:0] r_tries;
   logic [15:0]   r_answer;
   logic          r_valid;
   logic          r_busy;

   logic [15:0]   w_lfsr;
   logic [3:0]    w_cand;
   logic          w_cand_used;
   logic          w_accept;
   logic [3:0]    w_fill_digit;
   logic [3:0]    w_digit;
   logic          w_place;
   logic [9:0]    w_used_nxt;
   logic [15:0]   w_shadow_nxt;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk        (clk),
      .rst_n      (rst_n),
      .entropy_in (entropy_in),
      .q          (w_lfsr)
   );

   always_comb begin
      w_cand       = lfsr_digit(w_lfsr);
      w_cand_used  = 1'b0;
      w_fill_digit = 4'd0;
      for (int i = 0; i < 10; i++)
         if (r_used[i] && w_cand == 4'(i))
            w_cand_used = 1'b1;
      // Scan downwards so the lowest legal unused digit is the one that sticks.
      for (int i = 9; i >= 0; i--)
         if (!r_used[i] && !(!ALLOW_LZ && r_slot == 2'd0 && i == 0))
            w_fill_digit = 4'(i);

      w_accept = (w_cand <= BCD_MAX) && !w_cand_used &&
                 !(!ALLOW_LZ && r_slot == 2'd0 && w_cand == 4'd0);
      w_place  = (r_state == DRAW && w_accept) || (r_state == FILL);
      w_digit  = (r_state == FILL) ? w_fill_digit : w_cand;

      w_used_nxt = r_used;
      for (int i = 0; i < 10; i++)
         if (w_digit == 4'(i))
            w_used_nxt[i] = 1'b1;

      w_shadow_nxt = r_shadow;
      case (r_slot)
         2'd0:    w_shadow_nxt[15:12] = w_digit;
         2'd1:    w_shadow_nxt[11:8]  = w_digit;
         2'd2:    w_shadow_nxt[7:4]   = w_digit;
         default: w_shadow_nxt[3:0]   = w_digit;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_used   <= '0;
         r_shadow <= '0;
         r_slot   <= '0;
         r_tries  <= '0;
         r_answer <= RESET_ANSWER;
         r_valid  <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (new_game) begin
                  r_valid <= 1'b0;
                  r_busy  <= 1'b1;
                  r_slot  <= '0;
                  r_used  <= '0;
                  r_tries <= '0;
                  r_state <= (MAX_TRIES == 0) ? FILL : DRAW;
               end
            end
            DRAW, FILL: begin
               if (r_state == DRAW)
                  r_tries <= r_tries + 1'b1;
               if (w_place) begin
                  r_shadow <= w_shadow_nxt;
                  r_used   <= w_used_nxt;
               end
               if (w_place && r_slot == 2'(BC_DIGITS - 1)) begin
                  r_answer <= w_shadow_nxt;
                  r_valid  <= 1'b1;
                  r_busy   <= 1'b0;
                  r_state  <= IDLE;
               end else begin
                  if (w_place)
                     r_slot <= r_slot + 2'd1;
                  // Out of random tries with slots still open: finish deterministically.
                  if (r_state == DRAW && r_tries == TRIES_LAST)
                     r_state <= FILL;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign answer       = r_answer;
   assign answer_valid = r_valid;
   assign busy         = r_busy;

endmodule

// File: tb/tb_secret_gen.sv
// Scoreboarded bench for secret_gen: predicted answers are queued at request time.
module tb_secret_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        entropy_in = 1'b0;
   logic        ng_a = 1'b0, ng_b = 1'b0, ng_c = 1'b0;
   logic [15:0] ans_a, ans_b, ans_c;
   logic        val_a, val_b, val_c;
   logic        busy_a, busy_b, busy_c;

   always #5 clk = ~clk;

   secret_gen u_dut (
      .clk(clk), .rst_n(rst_n), .new_game(ng_a), .entropy_in(entropy_in),
      .answer(ans_a), .answer_valid(val_a), .busy(busy_a)
   );

   secret_gen #(.MAX_TRIES(0), .ALLOW_LZ(1'b1)) u_fill_lz (
      .clk(clk), .rst_n(rst_n), .new_game(ng_b), .entropy_in(entropy_in),
      .answer(ans_b), .answer_valid(val_b), .busy(busy_b)
   );

   secret_gen #(.MAX_TRIES(0), .ALLOW_LZ(1'b0)) u_fill_nlz (
      .clk(clk), .rst_n(rst_n), .new_game(ng_c), .entropy_in(entropy_in),
      .answer(ans_c), .answer_valid(val_c), .busy(busy_c)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference LFSR, tracked in lockstep from reset.
   function automatic logic [15:0] m_step(input logic [15:0] s, input logic e);
      logic [15:0] n;
      n = s >> 1;
      if (s[0]) n = n ^ 16'hB400;
      n[0] = n[0] ^ e;
      if (n == 16'h0000) n = 16'hACE1;
      return n;
   endfunction

   logic [15:0] m_lfsr;
   always @(posedge clk) m_lfsr <= !rst_n ? 16'hACE1 : m_step(m_lfsr, entropy_in);

   // Forward prediction of a draw with entropy held at zero; l0 is the LFSR before the request edge.
   task automatic predict(input logic [15:0] l0, output logic [15:0] ans, output int lat);
      logic [15:0] l;
      logic [9:0]  used;
      int          slot, tries, n;
      l = m_step(l0, 1'b0);
      lat = 1; slot = 0; tries = 0; used = '0; ans = '0;
      while (slot < 4 && tries < 64) begin
         lat++; tries++;
         n = int'(l[3:0]);
         if (n <= 9 && !used[n]) begin
            ans = ans | (16'(n) << (12 - 4 * slot));
            used[n] = 1'b1;
            slot++;
         end
         l = m_step(l, 1'b0);
      end
      while (slot < 4) begin
         lat++;
         n = 0;
         while (used[n]) n++;
         ans = ans | (16'(n) << (12 - 4 * slot));
         used[n] = 1'b1;
         slot++;
      end
   endtask

   function automatic bit digits_ok(input logic [15:0] a);
      logic [3:0] d [4];
      for (int i = 0; i < 4; i++) d[i] = a[4*i +: 4];
      for (int i = 0; i < 4; i++) begin
         if (d[i] > 4'd9) return 1'b0;
         for (int j = 0; j < i; j++)
            if (d[i] == d[j]) return 1'b0;
      end
      return 1'b1;
   endfunction

   logic [15:0] exp_q [$];
   int          lat_q [$];

   // One request on the default instance; repulse>0 re-asserts new_game that many edges in.
   task automatic run_draw(input int repulse, output logic [15:0] got);
      logic [15:0] e_ans;
      int          e_lat, cnt;
      @(negedge clk);
      entropy_in = 1'b0;
      predict(m_lfsr, e_ans, e_lat);
      exp_q.push_back(e_ans);
      lat_q.push_back(e_lat);
      ng_a = 1'b1;
      @(posedge clk); #1;
      ng_a = 1'b0;
      chk("busy_after_req", 32'(busy_a), 32'd1);
      chk("valid_after_req", 32'(val_a), 32'd0);
      cnt = 1;
      while (!val_a && cnt < 100) begin
         ng_a = (cnt == repulse);
         @(posedge clk); #1;
         ng_a = 1'b0;
         cnt++;
      end
      got = ans_a;
      chk("commit_seen", 32'(val_a), 32'd1);
      chk("answer", 32'(ans_a), 32'(exp_q.pop_front()));
      chk("latency", 32'(cnt), 32'(lat_q.pop_front()));
      chk("latency_bound", 32'(cnt <= 69), 32'd1);
      repeat (3) begin
         @(posedge clk); #1;
         chk("hold_valid", 32'(val_a), 32'd1);
         chk("hold_answer", 32'(ans_a), 32'(got));
      end
   endtask

   bit rand_en = 1'b0;
   bit mon_en  = 1'b0;
   int viol = 0;
   int zero_reads = 0;

   initial forever begin
      @(negedge clk);
      if (rand_en) entropy_in = 1'($urandom_range(0, 1));
   end

   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         if (val_a == busy_a) viol++;
         if (u_dut.u_lfsr.r_q == 16'h0000) zero_reads++;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ans2, ans4, ans5;
      int          lat_b, lat_c, cnt;

      // Reset held two edges.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_answer", 32'(ans_a), 32'h1234);
      chk("rst_valid", 32'(val_a), 32'd1);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_answer_fill", 32'(ans_c), 32'h1234);

      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      run_draw(0, ans2);
      chk("draw_digits", 32'(digits_ok(ans2)), 32'd1);

      // Deterministic fill instances.
      @(negedge clk);
      ng_b = 1'b1; ng_c = 1'b1;
      lat_b = 0; lat_c = 0;
      for (int e = 1; e <= 10; e++) begin
         @(posedge clk); #1;
         ng_b = 1'b0; ng_c = 1'b0;
         if (e == 1) begin
            chk("fill_busy", 32'(busy_b), 32'd1);
            chk("fill_valid_low", 32'(val_c), 32'd0);
         end
         if (val_b && lat_b == 0) lat_b = e;
         if (val_c && lat_c == 0) lat_c = e;
      end
      chk("fill_lz_answer", 32'(ans_b), 32'h0123);
      chk("fill_lz_latency", 32'(lat_b), 32'd5);
      chk("fill_nlz_answer", 32'(ans_c), 32'h1023);
      chk("fill_nlz_latency", 32'(lat_c), 32'd5);

      // Request during a draw must be ignored.
      run_draw(2, ans4);
      chk("repulse_no_restart_busy", 32'(busy_a), 32'd0);

      // Reset mid-draw, then the same post-reset timing as the first draw.
      @(negedge clk);
      ng_a = 1'b1;
      @(posedge clk); #1;
      ng_a = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_draw_busy", 32'(busy_a), 32'd1);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_answer", 32'(ans_a), 32'h1234);
      chk("midrst_valid", 32'(val_a), 32'd1);
      chk("midrst_busy", 32'(busy_a), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      run_draw(0, ans5);
      chk("replay_after_reset", 32'(ans5), 32'(ans2));

      // Random entropy soak.
      rand_en = 1'b1;
      mon_en  = 1'b1;
      for (int p = 0; p < 1000; p++) begin
         @(negedge clk);
         ng_a = 1'b1;
         @(posedge clk); #1;
         ng_a = 1'b0;
         cnt = 1;
         while (!val_a && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
         end
         chk("rand_commit", 32'(val_a), 32'd1);
         chk("rand_latency", 32'(cnt >= 5 && cnt <= 69), 32'd1);
         chk("rand_digits", 32'(digits_ok(ans_a)), 32'd1);
      end
      @(negedge clk);
      rand_en = 1'b0;
      mon_en  = 1'b0;
      chk("valid_busy_exclusive", 32'(viol), 32'd0);
      chk("lfsr_nonzero", 32'(zero_reads), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
